// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the decode/execute boundary.
//   WIDTH     datapath width
//   AW        register address width (32 registers)
//   CW        width of the opaque control bundle handed to EX
//   REG_ZERO  hardwired-zero register index; never written, never bypassed
//   CTRL_*    bit positions of the named fields inside ex_ctrl
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned WIDTH    = 32;
   localparam int unsigned AW       = 5;
   localparam int unsigned CW       = 12;

   localparam int unsigned REG_ZERO = 0;

   // Control bundle field layout, LSB first
   localparam int unsigned CTRL_REG_WRITE  = 0;
   localparam int unsigned CTRL_MEM_WRITE  = 1;
   localparam int unsigned CTRL_ALU_SRC    = 2;
   localparam int unsigned CTRL_ALU_OP_LO  = 3;
   localparam int unsigned CTRL_ALU_OP_HI  = 6;
   localparam int unsigned CTRL_BRANCH     = 7;
   localparam int unsigned CTRL_JUMP       = 8;
   localparam int unsigned CTRL_MEM_TO_REG = 9;
   localparam int unsigned CTRL_LINK       = 10;
   localparam int unsigned CTRL_SIGNED     = 11;

   localparam int unsigned ALU_OP_W = CTRL_ALU_OP_HI - CTRL_ALU_OP_LO + 1;

endpackage : cpu_pkg

// File: rtl/wb_bypass.sv
// ---------------------------------------------------------------------------
// wb_bypass
// Compare-and-mux that substitutes the writeback value for a register
// operand when the writeback targets the same (non-zero) register in the
// same cycle. Used for both fresh capture and refresh of held operands.
//   src_addr     register address the operand was read from
//   src_data     operand value as currently known
//   wb_wrenable  writeback enable
//   wb_addr      writeback address
//   wb_data      writeback data
//   byp_data_c   operand after bypass (combinational)
// ---------------------------------------------------------------------------
module wb_bypass #(
   parameter int unsigned WIDTH = cpu_pkg::WIDTH,
   parameter int unsigned AW    = cpu_pkg::AW
) (
   input  logic [AW-1:0]    src_addr,
   input  logic [WIDTH-1:0] src_data,
   input  logic             wb_wrenable,
   input  logic [AW-1:0]    wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   output logic [WIDTH-1:0] byp_data_c
);

   import cpu_pkg::*;

   // Register zero always reads as its stored value; it is never forwarded.
   always_comb begin
      byp_data_c = src_data;
      if (wb_wrenable && (wb_addr == src_addr) && (src_addr != AW'(REG_ZERO))) begin
         byp_data_c = wb_data;
      end
   end

endmodule : wb_bypass

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID->EX pipeline register. Captures register-file read data (with a
// same-cycle writeback bypass), addresses, immediate and control, inserts a
// bubble on a load-use hazard, and honours flush and downstream stall.
//   clk, reset                 clock, synchronous active-high reset
//   id_valid                   ID holds a real instruction
//   id_rs_addr/id_rt_addr      source register addresses
//   id_rd_addr                 destination register address
//   id_rs_data/id_rt_data      register-file read ports A/B
//   id_imm, id_ctrl            immediate and control bundle
//   id_mem_read                instruction is a load
//   wb_wrenable/wb_addr/wb_data  writeback port (same as regfile write)
//   ex_stall                   EX cannot accept; hold contents
//   flush                      kill the instruction being captured
//   ex_*                       registered stage contents presented to EX
//   id_stall                   IF/ID must hold (combinational)
// ---------------------------------------------------------------------------
module id_ex_stage #(
   parameter int unsigned WIDTH = cpu_pkg::WIDTH,
   parameter int unsigned AW    = cpu_pkg::AW,
   parameter int unsigned CW    = cpu_pkg::CW
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs_addr,
   input  logic [AW-1:0]    id_rt_addr,
   input  logic [AW-1:0]    id_rd_addr,
   input  logic [WIDTH-1:0] id_rs_data,
   input  logic [WIDTH-1:0] id_rt_data,
   input  logic [WIDTH-1:0] id_imm,
   input  logic [CW-1:0]    id_ctrl,
   input  logic             id_mem_read,

   input  logic             wb_wrenable,
   input  logic [AW-1:0]    wb_addr,
   input  logic [WIDTH-1:0] wb_data,

   input  logic             ex_stall,
   input  logic             flush,

   output logic             ex_valid,
   output logic [WIDTH-1:0] ex_rs_data,
   output logic [WIDTH-1:0] ex_rt_data,
   output logic [AW-1:0]    ex_rs_addr,
   output logic [AW-1:0]    ex_rt_addr,
   output logic [AW-1:0]    ex_rd_addr,
   output logic [WIDTH-1:0] ex_imm,
   output logic [CW-1:0]    ex_ctrl,
   output logic             ex_mem_read,

   output logic             id_stall
);

   import cpu_pkg::*;

   logic [WIDTH-1:0] cap_rs_data_c;
   logic [WIDTH-1:0] cap_rt_data_c;
   logic [WIDTH-1:0] hold_rs_data_c;
   logic [WIDTH-1:0] hold_rt_data_c;
   logic             hazard_c;

   // Fresh operands: the regfile returns the pre-write value on a same-cycle
   // read, so forward the writeback data instead.
   wb_bypass #(.WIDTH(WIDTH), .AW(AW)) u_cap_rs (
      .src_addr    (id_rs_addr),
      .src_data    (id_rs_data),
      .wb_wrenable (wb_wrenable),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .byp_data_c  (cap_rs_data_c)
   );

   wb_bypass #(.WIDTH(WIDTH), .AW(AW)) u_cap_rt (
      .src_addr    (id_rt_addr),
      .src_data    (id_rt_data),
      .wb_wrenable (wb_wrenable),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .byp_data_c  (cap_rt_data_c)
   );

   // Held operands: a producer may retire while EX is stalled, so the held
   // value must pick up that writeback or it goes stale.
   wb_bypass #(.WIDTH(WIDTH), .AW(AW)) u_hold_rs (
      .src_addr    (ex_rs_addr),
      .src_data    (ex_rs_data),
      .wb_wrenable (wb_wrenable),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .byp_data_c  (hold_rs_data_c)
   );

   wb_bypass #(.WIDTH(WIDTH), .AW(AW)) u_hold_rt (
      .src_addr    (ex_rt_addr),
      .src_data    (ex_rt_data),
      .wb_wrenable (wb_wrenable),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .byp_data_c  (hold_rt_data_c)
   );

   // Load in EX whose destination feeds the instruction now in ID.
   always_comb begin
      hazard_c = ex_valid
               & ex_mem_read
               & (ex_rd_addr != AW'(REG_ZERO))
               & id_valid
               & ((ex_rd_addr == id_rs_addr) | (ex_rd_addr == id_rt_addr));
      // A flush discards the ID instruction, so there is nothing to hold.
      id_stall = (hazard_c | ex_stall) & ~flush;
   end

   // Stage register: reset > flush > stall (hold+refresh) > bubble > capture.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ex_valid    <= 1'b0;
         ex_rs_data  <= '0;
         ex_rt_data  <= '0;
         ex_rs_addr  <= '0;
         ex_rt_addr  <= '0;
         ex_rd_addr  <= '0;
         ex_imm      <= '0;
         ex_ctrl     <= '0;
         ex_mem_read <= 1'b0;
      end else if (ex_stall) begin
         ex_rs_data  <= hold_rs_data_c;
         ex_rt_data  <= hold_rt_data_c;
      end else if (hazard_c) begin
         ex_valid    <= 1'b0;
         ex_rs_data  <= '0;
         ex_rt_data  <= '0;
         ex_rs_addr  <= '0;
         ex_rt_addr  <= '0;
         ex_rd_addr  <= '0;
         ex_imm      <= '0;
         ex_ctrl     <= '0;
         ex_mem_read <= 1'b0;
      end else begin
         ex_valid    <= id_valid;
         ex_rs_data  <= cap_rs_data_c;
         ex_rt_data  <= cap_rt_data_c;
         ex_rs_addr  <= id_rs_addr;
         ex_rt_addr  <= id_rt_addr;
         ex_rd_addr  <= id_rd_addr;
         ex_imm      <= id_imm;
         // An empty slot must not carry side-effecting control into EX.
         ex_ctrl     <= id_valid ? id_ctrl : '0;
         ex_mem_read <= id_mem_read & id_valid;
      end
   end

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   localparam int unsigned W = cpu_pkg::WIDTH;
   localparam int unsigned A = cpu_pkg::AW;
   localparam int unsigned C = cpu_pkg::CW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         id_valid;
   logic [A-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
   logic [W-1:0] id_rs_data, id_rt_data, id_imm;
   logic [C-1:0] id_ctrl;
   logic         id_mem_read;
   logic         wb_wrenable;
   logic [A-1:0] wb_addr;
   logic [W-1:0] wb_data;
   logic         ex_stall, flush;

   logic         ex_valid;
   logic [W-1:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [A-1:0] ex_rs_addr, ex_rt_addr, ex_rd_addr;
   logic [C-1:0] ex_ctrl;
   logic         ex_mem_read;
   logic         id_stall;

   id_ex_stage dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rd_addr(id_rd_addr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
      .wb_wrenable(wb_wrenable), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_stall(ex_stall), .flush(flush),
      .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr),
      .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
      .id_stall(id_stall)
   );

   // Expected contents of the EX slot
   typedef struct {
      logic         valid;
      logic [W-1:0] rs_data, rt_data, imm;
      logic [A-1:0] rs_addr, rt_addr, rd_addr;
      logic [C-1:0] ctrl;
      logic         mem_read;
   } slot_t;

   slot_t mdl;
   bit    mdl_init = 1'b0;
   int    n_cmp = 0;
   int    n_err = 0;

   function automatic slot_t empty_slot();
      slot_t s;
      s.valid = 1'b0; s.rs_data = '0; s.rt_data = '0; s.imm = '0;
      s.rs_addr = '0; s.rt_addr = '0; s.rd_addr = '0; s.ctrl = '0; s.mem_read = 1'b0;
      return s;
   endfunction

   // Value register a would hold after this cycle's writeback lands.
   function automatic logic [W-1:0] newest(logic [A-1:0] a, logic [W-1:0] d);
      if (wb_wrenable && wb_addr == a && a != '0) return wb_data;
      return d;
   endfunction

   function automatic bit load_use();
      return mdl.valid && mdl.mem_read && mdl.rd_addr != '0 && id_valid &&
             (mdl.rd_addr == id_rs_addr || mdl.rd_addr == id_rt_addr);
   endfunction

   function automatic bit exp_stall();
      return (load_use() || ex_stall) && !flush;
   endfunction

   function automatic slot_t exp_next();
      slot_t n;
      if (reset || flush) return empty_slot();
      if (ex_stall) begin
         n = mdl;
         n.rs_data = newest(mdl.rs_addr, mdl.rs_data);
         n.rt_data = newest(mdl.rt_addr, mdl.rt_data);
         return n;
      end
      if (load_use()) return empty_slot();
      n.valid    = id_valid;
      n.rs_data  = newest(id_rs_addr, id_rs_data);
      n.rt_data  = newest(id_rt_addr, id_rt_data);
      n.rs_addr  = id_rs_addr;
      n.rt_addr  = id_rt_addr;
      n.rd_addr  = id_rd_addr;
      n.imm      = id_imm;
      n.ctrl     = id_valid ? id_ctrl : '0;
      n.mem_read = id_valid && id_mem_read;
      return n;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic check_slot();
      chk("ex_valid",    32'(ex_valid),    32'(mdl.valid));
      chk("ex_rs_data",  ex_rs_data,       mdl.rs_data);
      chk("ex_rt_data",  ex_rt_data,       mdl.rt_data);
      chk("ex_rs_addr",  32'(ex_rs_addr),  32'(mdl.rs_addr));
      chk("ex_rt_addr",  32'(ex_rt_addr),  32'(mdl.rt_addr));
      chk("ex_rd_addr",  32'(ex_rd_addr),  32'(mdl.rd_addr));
      chk("ex_imm",      ex_imm,           mdl.imm);
      chk("ex_ctrl",     32'(ex_ctrl),     32'(mdl.ctrl));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(mdl.mem_read));
   endtask

   task automatic idle();
      reset = 1'b0; id_valid = 1'b0;
      id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0;
      id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_ctrl = '0; id_mem_read = 1'b0;
      wb_wrenable = 1'b0; wb_addr = '0; wb_data = '0;
      ex_stall = 1'b0; flush = 1'b0;
   endtask

   // Called just after a negedge with inputs applied: checks id_stall,
   // advances one clock, checks the stage, returns at the next negedge.
   task automatic tick();
      slot_t nxt;
      #1;
      if (mdl_init) chk("id_stall", 32'(id_stall), 32'(exp_stall()));
      nxt = exp_next();
      @(posedge clk);
      mdl = nxt;
      mdl_init = 1'b1;
      #1;
      check_slot();
      @(negedge clk);
   endtask

   initial begin
      idle();
      @(negedge clk);

      // Reset with every input nonzero
      reset = 1'b1; id_valid = 1'b1; id_rs_addr = 5'd9; id_rt_addr = 5'd10;
      id_rd_addr = 5'd11; id_rs_data = 32'h1111_1111; id_rt_data = 32'h2222_2222;
      id_imm = 32'h3333_3333; id_ctrl = 12'hFFF; id_mem_read = 1'b1;
      wb_wrenable = 1'b1; wb_addr = 5'd9; wb_data = 32'h4444_4444;
      ex_stall = 1'b1; flush = 1'b1;
      tick();
      idle();
      #1;
      chk("reset_id_stall", 32'(id_stall), 32'd0);
      chk("reset_ex_valid", 32'(ex_valid), 32'd0);
      chk("reset_ex_ctrl",  32'(ex_ctrl),  32'd0);
      chk("reset_rs_data",  ex_rs_data,    32'd0);

      // Same-cycle writeback bypass
      id_valid = 1'b1; id_rs_addr = 5'd5; id_rs_data = 32'h11;
      wb_wrenable = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD;
      tick();
      chk("byp_rs", ex_rs_data, 32'hDEAD);
      id_rs_addr = 5'd0; id_rs_data = 32'h0; wb_addr = 5'd0;
      tick();
      chk("byp_zero", ex_rs_data, 32'h0);
      id_rs_addr = 5'd7; id_rt_addr = 5'd7; id_rs_data = 32'h1; id_rt_data = 32'h2;
      wb_addr = 5'd7; wb_data = 32'hBEEF;
      tick();
      chk("byp_both_rs", ex_rs_data, 32'hBEEF);
      chk("byp_both_rt", ex_rt_data, 32'hBEEF);

      // Load-use: one bubble, then capture
      idle();
      id_valid = 1'b1; id_mem_read = 1'b1; id_rd_addr = 5'd8;
      id_rs_addr = 5'd1; id_rt_addr = 5'd2; id_ctrl = 12'h201;
      tick();
      idle();
      id_valid = 1'b1; id_rs_addr = 5'd8; id_rt_addr = 5'd3; id_rd_addr = 5'd4;
      id_ctrl = 12'h123;
      #1;
      chk("lu_stall", 32'(id_stall), 32'd1);
      tick();
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      chk("lu_bubble_ctrl",  32'(ex_ctrl),  32'd0);
      #1;
      chk("lu_release", 32'(id_stall), 32'd0);
      tick();
      chk("lu_cap_valid", 32'(ex_valid), 32'd1);
      chk("lu_cap_ctrl",  32'(ex_ctrl),  32'h123);

      // Flush beats stall
      ex_stall = 1'b1; flush = 1'b1;
      #1;
      chk("fl_stall", 32'(id_stall), 32'd0);
      tick();
      chk("fl_valid", 32'(ex_valid), 32'd0);

      // Held-operand refresh during a 3-cycle stall
      idle();
      id_valid = 1'b1; id_rs_addr = 5'd4; id_rt_addr = 5'd3; id_rd_addr = 5'd6;
      id_rt_data = 32'h10; id_rs_data = 32'h20; id_imm = 32'h77; id_ctrl = 12'hABC;
      tick();
      id_rs_addr = 5'd12; id_rt_addr = 5'd13; id_rt_data = 32'h99; id_ctrl = 12'h555;
      ex_stall = 1'b1;
      #1;
      chk("hold_id_stall", 32'(id_stall), 32'd1);
      tick();
      chk("hold1_rt", ex_rt_data, 32'h10);
      wb_wrenable = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
      tick();
      chk("hold2_rt", ex_rt_data, 32'h55);
      wb_wrenable = 1'b0;
      tick();
      chk("hold3_rt",   ex_rt_data,      32'h55);
      chk("hold3_rs",   ex_rs_data,      32'h20);
      chk("hold3_ctrl", 32'(ex_ctrl),    32'hABC);
      chk("hold3_imm",  ex_imm,          32'h77);

      // Non-load producer causes no stall
      idle();
      id_valid = 1'b1; id_rd_addr = 5'd8; id_ctrl = 12'h001;
      tick();
      idle();
      id_valid = 1'b1; id_rs_addr = 5'd8;
      #1;
      chk("nl_stall", 32'(id_stall), 32'd0);
      tick();
      chk("nl_valid",   32'(ex_valid),   32'd1);
      chk("nl_rs_addr", 32'(ex_rs_addr), 32'd8);

      // Randomized traffic with small address space to force collisions
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 63) == 0);
         flush       = ($urandom_range(0, 9) == 0);
         ex_stall    = ($urandom_range(0, 3) == 0);
         id_valid    = ($urandom_range(0, 4) != 0);
         id_rs_addr  = A'($urandom_range(0, 3));
         id_rt_addr  = A'($urandom_range(0, 3));
         id_rd_addr  = A'($urandom_range(0, 3));
         id_rs_data  = $urandom;
         id_rt_data  = $urandom;
         id_imm      = $urandom;
         id_ctrl     = C'($urandom);
         id_mem_read = ($urandom_range(0, 2) == 0);
         wb_wrenable = ($urandom_range(0, 1) == 1);
         wb_addr     = A'($urandom_range(0, 3));
         wb_data     = $urandom;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_id_ex_stage
